daq_adc_reader: RTL and testbench
=================================

Name: daq_adc_reader

Overview:
- Downstream stage of the DAQ trigger controller. Consumes its conversion pulse (conv_clk_o) and the ADC BUSY line.
- After each conversion completes, performs NUM_CH parallel-bus reads from a simultaneous-sampling ADC (CS_n/RD_n strobed).
- Delivers samples on a valid/ready stream tagged with channel index.
- Drives busy_o, which feeds back into the trigger controller's busy_i.

Parameters:
- NUM_CH, 8: channels read per conversion frame (>=2).
- DATA_W, 16: ADC parallel data width.
- RD_LOW_CYC, 2: clk_i cycles RD_n is held low per read (>=1).
- RD_HIGH_CYC, 2: minimum clk_i cycles RD_n is held high between reads (>=1).
- BUSY_TIMEOUT, 255: maximum cycles spent waiting for each BUSY edge.
- CH_W, $clog2(NUM_CH): channel index width (derived).

Ports:
- clk_i  in  1  system clock (DCM fast clock domain)
- reset_i  in  1  asynchronous, active-low reset
- en_i  in  1  frame-start enable; gates only new frames
- conv_i  in  1  conversion pulse from the trigger controller, synchronous to clk_i
- busy_i  in  1  ADC BUSY, asynchronous
- adc_data_i  in  DATA_W  ADC parallel data bus
- adc_cs_n_o  out  1  ADC chip select, active-low
- adc_rd_n_o  out  1  ADC read strobe, active-low
- sample_o  out  DATA_W  captured sample
- chan_o  out  CH_W  channel index of sample_o
- sample_valid_o  out  1  sample_o/chan_o valid
- sample_ready_i  in  1  consumer accepts when valid&ready
- frame_last_o  out  1  high with the valid sample of channel NUM_CH-1
- busy_o  out  1  reader active (any state other than IDLE)
- overrun_o  out  1  sticky: conv edge arrived while not IDLE
- timeout_o  out  1  sticky: BUSY edge not seen within BUSY_TIMEOUT
- clr_i  in  1  synchronous clear of overrun_o and timeout_o
- frame_cnt_o  out  16  completed frames, wraps at 0xFFFF->0

Behaviour:
- Reset (async, reset_i=0): state IDLE.
  - adc_cs_n_o=1, adc_rd_n_o=1.
  - sample_valid_o=0, frame_last_o=0, sample_o=0, chan_o=0.
  - busy_o=0, overrun_o=0, timeout_o=0, frame_cnt_o=0.
  - Channel counter, timers and BUSY synchroniser flops cleared.
  - Reset mid-frame aborts immediately; no partial-frame output.
- busy_i passes through a 2-flop synchroniser (busy_s). All BUSY decisions use busy_s.
- conv edge = conv_i & ~conv_q, where conv_q is conv_i registered.
- IDLE:
  - On a conv edge with en_i=1: next cycle enter WAIT_HI, busy_o=1, timer=0.
  - On a conv edge with en_i=0: ignored, no flag set.
- WAIT_HI:
  - busy_s=1 -> WAIT_LO, timer=0.
  - Else, when timer reaches BUSY_TIMEOUT -> timeout_o=1, return to IDLE.
- WAIT_LO:
  - busy_s=0 -> RD_LO with adc_cs_n_o=0, adc_rd_n_o=0, ch=0.
  - Timeout rule is the same as in WAIT_HI.
- RD_LO:
  - adc_rd_n_o=0 for exactly RD_LOW_CYC cycles.
  - adc_data_i is captured into the hold register on the last RD_LO cycle.
  - Then enter RD_HI with adc_rd_n_o=1.
- RD_HI:
  - Hold register moves to the output register in the first cycle where the output is empty or being accepted (~sample_valid_o | sample_ready_i).
  - sample_valid_o=1, chan_o=ch, frame_last_o=(ch==NUM_CH-1).
  - Exit RD_HI only when RD_HIGH_CYC cycles have elapsed AND the transfer has happened. If the consumer stalls, RD_n stays high indefinitely; no sample is ever dropped.
  - If ch<NUM_CH-1: ch++, go to RD_LO.
  - Else: adc_cs_n_o=1, frame_cnt_o++, go to IDLE (busy_o=0 next cycle).
- Output register: sample_valid_o stays high, and sample_o/chan_o/frame_last_o stay stable, until valid&ready. It then clears unless reloaded in the same cycle.
- Overrun: a conv edge in any non-IDLE state sets overrun_o and is otherwise ignored. The current frame continues.
- en_i deassertion mid-frame does not abort; the current frame completes.
- clr_i clears both sticky flags. If a set event and clr_i occur in the same cycle, set wins.
- Minimum latency, BUSY falling edge (at busy_i) -> first sample_valid_o: 2 sync + 1 + RD_LOW_CYC + 1 cycles = 6 cycles at defaults.

Test Plan:
- Nominal frame: defaults, ready tied 1, conv edge; busy_i high 20 cycles then low; adc_data_i = 0x1000+ch during each read. Required: 8 samples 0x1000..0x1007 with chan_o 0..7, frame_last_o only with ch 7, frame_cnt_o=1, busy_o low after frame, RD_n low 2 cycles per read.
- Backpressure: sample_ready_i=0 for 10 cycles on ch 3. Required: RD_n stays high, sample_o=0x1003 held stable, then the remaining channels follow with no loss or duplication.
- Overrun: second conv edge during ch 2 read. Required: overrun_o=1, frame completes normally with 8 samples, no second frame. Then clr_i=1 for 1 cycle -> overrun_o=0.
- Timeout: conv edge, busy_i held 0. Required: timeout_o=1 after 255 cycles in WAIT_HI, back in IDLE, cs_n stays 1, frame_cnt_o unchanged.
- Reset mid-frame: reset_i=0 during ch 5 read. Required: immediately cs_n=1, rd_n=1, valid=0, all flags/counters 0. The next conv edge runs a full frame from ch 0.
- Counter wrap/enable: force 65536 frames (or preload via bench hierarchy) -> frame_cnt_o wraps to 0. Conv edge with en_i=0 -> no activity, overrun_o stays 0.

Source files
------------

// File: rtl/daq_adc_reader.sv
// Reads NUM_CH channels from a simultaneous-sampling parallel ADC after each
// conversion and streams the samples out on a valid/ready interface.
module daq_adc_reader #(
    parameter int NUM_CH       = 8,
    parameter int DATA_W       = 16,
    parameter int RD_LOW_CYC   = 2,
    parameter int RD_HIGH_CYC  = 2,
    parameter int BUSY_TIMEOUT = 255,
    parameter int CH_W         = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              en_i,
    input  logic              conv_i,
    input  logic              busy_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic              adc_cs_n_o,
    output logic              adc_rd_n_o,
    output logic [DATA_W-1:0] sample_o,
    output logic [CH_W-1:0]   chan_o,
    output logic              sample_valid_o,
    input  logic              sample_ready_i,
    output logic              frame_last_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic              timeout_o,
    input  logic              clr_i,
    output logic [15:0]       frame_cnt_o
);

    localparam int TMR_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam int CNT_MAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RD_LO,
        S_RD_HI
    } state_t;

    state_t              state_q;
    logic                busy_meta_q, busy_s_q, conv_q;
    logic [TMR_W-1:0]    timer_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CH_W-1:0]     ch_q;
    logic [DATA_W-1:0]   hold_q;
    logic                xfer_q;
    logic [DATA_W-1:0]   sample_q;
    logic [CH_W-1:0]     chan_q;
    logic                valid_q, last_q;
    logic                cs_n_q, rd_n_q, busy_q;
    logic                overrun_q, timeout_q;
    logic [15:0]         frame_cnt_q;

    logic conv_edge, load_out, rd_hi_exit, last_ch, to_hit, timeout_set;
    logic overrun_d, timeout_d;

    always_comb begin
        conv_edge   = conv_i & ~conv_q;
        last_ch     = (ch_q == CH_W'(NUM_CH - 1));
        to_hit      = (timer_q == TMR_W'(BUSY_TIMEOUT));
        // The held sample moves out exactly once per read, whenever the output slot frees up.
        load_out    = (state_q == S_RD_HI) && !xfer_q && (!valid_q || sample_ready_i);
        rd_hi_exit  = (state_q == S_RD_HI) && (cnt_q >= CNT_W'(RD_HIGH_CYC - 1))
                      && (xfer_q || load_out);
        timeout_set = to_hit && (((state_q == S_WAIT_HI) && !busy_s_q) ||
                                 ((state_q == S_WAIT_LO) &&  busy_s_q));
        // Set events take priority over a simultaneous clear.
        overrun_d   = (overrun_q & ~clr_i) | (conv_edge && (state_q != S_IDLE));
        timeout_d   = (timeout_q & ~clr_i) | timeout_set;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
            conv_q      <= 1'b0;
            timer_q     <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            hold_q      <= '0;
            xfer_q      <= 1'b0;
            sample_q    <= '0;
            chan_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            busy_meta_q <= busy_i;
            busy_s_q    <= busy_meta_q;
            conv_q      <= conv_i;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;

            if (valid_q && sample_ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_out) begin
                sample_q <= hold_q;
                chan_q   <= ch_q;
                last_q   <= last_ch;
                valid_q  <= 1'b1;
                xfer_q   <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (conv_edge && en_i) begin
                        state_q <= S_WAIT_HI;
                        busy_q  <= 1'b1;
                        timer_q <= '0;
                    end
                end
                S_WAIT_HI: begin
                    if (busy_s_q) begin
                        state_q <= S_WAIT_LO;
                        timer_q <= '0;
                    end else if (to_hit) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_WAIT_LO: begin
                    if (!busy_s_q) begin
                        state_q <= S_RD_LO;
                        cs_n_q  <= 1'b0;
                        rd_n_q  <= 1'b0;
                        ch_q    <= '0;
                        cnt_q   <= '0;
                    end else if (to_hit) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                S_RD_LO: begin
                    if (cnt_q == CNT_W'(RD_LOW_CYC - 1)) begin
                        hold_q  <= adc_data_i;
                        rd_n_q  <= 1'b1;
                        cnt_q   <= '0;
                        xfer_q  <= 1'b0;
                        state_q <= S_RD_HI;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RD_HI: begin
                    // A stalled consumer keeps RD_n high here until the sample is handed over.
                    if (rd_hi_exit) begin
                        cnt_q <= '0;
                        if (!last_ch) begin
                            ch_q    <= ch_q + CH_W'(1);
                            rd_n_q  <= 1'b0;
                            state_q <= S_RD_LO;
                        end else begin
                            cs_n_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            state_q     <= S_IDLE;
                        end
                    end else if (cnt_q < CNT_W'(RD_HIGH_CYC - 1)) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cs_n_q  <= 1'b1;
                    rd_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign adc_cs_n_o     = cs_n_q;
    assign adc_rd_n_o     = rd_n_q;
    assign sample_o       = sample_q;
    assign chan_o         = chan_q;
    assign sample_valid_o = valid_q;
    assign frame_last_o   = last_q;
    assign busy_o         = busy_q;
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;
    assign frame_cnt_o    = frame_cnt_q;

endmodule

// File: tb/tb_daq_adc_reader.sv
// Directed/randomized bench for daq_adc_reader: an ADC model feeds per-read data,
// accepted samples are scored against frames predicted from the channel/base rules.
module tb_daq_adc_reader;

    localparam int NUM_CH      = 8;
    localparam int DATA_W      = 16;
    localparam int RD_LOW_CYC  = 2;
    localparam int RD_HIGH_CYC = 2;
    localparam int CH_W        = 3;

    logic              clk_i, reset_i, en_i, conv_i, busy_i, clr_i, sample_ready_i;
    logic [DATA_W-1:0] adc_data_i;
    logic              adc_cs_n_o, adc_rd_n_o, sample_valid_o, frame_last_o;
    logic              busy_o, overrun_o, timeout_o;
    logic [DATA_W-1:0] sample_o;
    logic [CH_W-1:0]   chan_o;
    logic [15:0]       frame_cnt_o;

    daq_adc_reader #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .RD_LOW_CYC(RD_LOW_CYC),
        .RD_HIGH_CYC(RD_HIGH_CYC), .BUSY_TIMEOUT(255), .CH_W(CH_W)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .conv_i(conv_i),
        .busy_i(busy_i), .adc_data_i(adc_data_i), .adc_cs_n_o(adc_cs_n_o),
        .adc_rd_n_o(adc_rd_n_o), .sample_o(sample_o), .chan_o(chan_o),
        .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
        .frame_last_o(frame_last_o), .busy_o(busy_o), .overrun_o(overrun_o),
        .timeout_o(timeout_o), .clr_i(clr_i), .frame_cnt_o(frame_cnt_o)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  ch;
        logic        last;
    } smp_t;

    smp_t        exp_q[$];
    smp_t        got_q[$];
    smp_t        stall_s;
    logic        stall_prev;
    int          total = 0;
    int          bad = 0;
    int          rd_viol = 0;
    int          hi_viol = 0;
    int          stab_viol = 0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          ready_mode = 1;
    int          adc_idx = 0;
    logic        adc_prev_rd = 1'b1;
    logic [15:0] frame_base = 16'h1000;
    logic [15:0] exp_frames = 16'd0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Consumer ready: 0 = stall, 1 = always ready, 2 = random.
    initial begin
        sample_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #2;
            case (ready_mode)
                0:       sample_ready_i = 1'b0;
                1:       sample_ready_i = 1'b1;
                default: sample_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ADC model: the n-th read of a frame returns frame_base + n.
    initial begin
        adc_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (adc_cs_n_o) adc_idx = 0;
            else if (!adc_prev_rd && adc_rd_n_o) adc_idx++;
            adc_prev_rd = adc_rd_n_o;
            adc_data_i  = frame_base + 16'(adc_idx);
        end
    end

    // Observer: collects accepted samples, stall stability and RD_n timing.
    initial begin
        stall_prev = 1'b0;
        stall_s    = '0;
        forever begin
            @(negedge clk_i);
            if (!reset_i) begin
                lo_cnt     = 0;
                hi_cnt     = 0;
                stall_prev = 1'b0;
            end else begin
                if (sample_valid_o && sample_ready_i)
                    got_q.push_back(smp_t'({sample_o, chan_o, frame_last_o}));
                if (stall_prev && !(sample_valid_o && smp_t'({sample_o, chan_o, frame_last_o}) == stall_s))
                    stab_viol++;
                stall_prev = sample_valid_o && !sample_ready_i;
                stall_s    = smp_t'({sample_o, chan_o, frame_last_o});
                if (!adc_rd_n_o) begin
                    if (hi_cnt > 0 && hi_cnt < RD_HIGH_CYC) hi_viol++;
                    hi_cnt = 0;
                    lo_cnt++;
                end else begin
                    if (lo_cnt != 0 && lo_cnt != RD_LOW_CYC) rd_viol++;
                    lo_cnt = 0;
                    if (!adc_cs_n_o) hi_cnt++;
                    else hi_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_frame(input logic [15:0] base);
        smp_t s;
        for (int c = 0; c < NUM_CH; c++) begin
            s.d    = base + 16'(c);
            s.ch   = 3'(c);
            s.last = (c == NUM_CH - 1);
            exp_q.push_back(s);
        end
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_smp[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic start_conv();
        conv_i = 1'b1;
        cyc(1);
        conv_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 3000) begin
            cyc(1);
            n++;
        end
        check(tag, 32'(n < 3000), 32'd1);
    endtask

    task automatic run_frame(input logic [15:0] base, input int gap, input int hi);
        frame_base = base;
        push_frame(base);
        start_conv();
        cyc(gap);
        busy_i = 1'b1;
        cyc(hi);
        busy_i = 1'b0;
        wait_idle("frame_end");
        exp_frames++;
    endtask

    initial begin
        int   n;
        logic flag;
        reset_i = 1'b0;
        en_i    = 1'b1;
        conv_i  = 1'b0;
        busy_i  = 1'b0;
        clr_i   = 1'b0;
        cyc(3);

        // Reset state
        check("rst_cs_n", 32'(adc_cs_n_o), 32'd1);
        check("rst_rd_n", 32'(adc_rd_n_o), 32'd1);
        check("rst_valid", 32'(sample_valid_o), 32'd0);
        check("rst_last", 32'(frame_last_o), 32'd0);
        check("rst_sample", 32'(sample_o), 32'd0);
        check("rst_chan", 32'(chan_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
        check("rst_to", 32'(timeout_o), 32'd0);
        check("rst_fcnt", 32'(frame_cnt_o), 32'd0);
        reset_i = 1'b1;
        cyc(2);

        // Nominal frame with latency measurement
        frame_base = 16'h1000;
        push_frame(16'h1000);
        start_conv();
        cyc(2);
        check("nom_busy_on", 32'(busy_o), 32'd1);
        busy_i = 1'b1;
        cyc(20);
        busy_i = 1'b0;
        n = 0;
        do begin
            cyc(1);
            n++;
        end while (!sample_valid_o && n < 100);
        check("nom_latency", 32'(n), 32'd6);
        wait_idle("nom_end");
        exp_frames++;
        compare("nom");
        check("nom_fcnt", 32'(frame_cnt_o), 32'(exp_frames));
        check("nom_busy_off", 32'(busy_o), 32'd0);
        check("nom_cs_n", 32'(adc_cs_n_o), 32'd1);
        check("nom_rd_low", 32'(rd_viol), 32'd0);
        check("nom_rd_high", 32'(hi_viol), 32'd0);

        // Backpressure on channel 3
        frame_base = 16'h1000;
        push_frame(16'h1000);
        start_conv();
        cyc(2);
        busy_i = 1'b1;
        cyc(5);
        busy_i = 1'b0;
        n = 0;
        while (!(sample_valid_o && chan_o == 3'd3) && n < 200) begin
            cyc(1);
            n++;
        end
        check("bp_reach", 32'(n < 200), 32'd1);
        ready_mode = 0;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (i >= 4 && !adc_rd_n_o) flag = 1'b1;
        end
        check("bp_rd_held", 32'(flag), 32'd0);
        check("bp_sample", 32'(sample_o), 32'h1003);
        check("bp_chan", 32'(chan_o), 32'd3);
        check("bp_valid", 32'(sample_valid_o), 32'd1);
        ready_mode = 1;
        wait_idle("bp_end");
        exp_frames++;
        compare("bp");
        check("bp_stable", 32'(stab_viol), 32'd0);
        check("bp_fcnt", 32'(frame_cnt_o), 32'(exp_frames));

        // Random frames under random backpressure
        ready_mode = 2;
        for (int f = 0; f < 3; f++)
            run_frame(16'($urandom), $urandom_range(1, 10), $urandom_range(1, 40));
        ready_mode = 1;
        cyc(2);
        compare("rnd");
        check("rnd_fcnt", 32'(frame_cnt_o), 32'(exp_frames));
        check("rnd_stable", 32'(stab_viol), 32'd0);
        check("rnd_rd_low", 32'(rd_viol), 32'd0);
        check("rnd_rd_high", 32'(hi_viol), 32'd0);

        // Overrun during channel 2 read
        frame_base = 16'($urandom);
        push_frame(frame_base);
        start_conv();
        cyc(2);
        busy_i = 1'b1;
        cyc(4);
        busy_i = 1'b0;
        n = 0;
        while (got_q.size() < 2 && n < 200) begin
            cyc(1);
            n++;
        end
        check("ovr_reach", 32'(n < 200), 32'd1);
        check("ovr_pre", 32'(overrun_o), 32'd0);
        start_conv();
        check("ovr_set", 32'(overrun_o), 32'd1);
        wait_idle("ovr_end");
        exp_frames++;
        cyc(20);
        check("ovr_no_2nd", 32'(busy_o), 32'd0);
        compare("ovr");
        check("ovr_fcnt", 32'(frame_cnt_o), 32'(exp_frames));
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        check("ovr_clr", 32'(overrun_o), 32'd0);

        // Timeout waiting for BUSY high
        start_conv();
        flag = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cyc(1);
            if (!adc_cs_n_o) flag = 1'b1;
        end
        check("to_early", 32'(timeout_o), 32'd0);
        check("to_busy_wait", 32'(busy_o), 32'd1);
        n = 0;
        while (!timeout_o && n < 100) begin
            cyc(1);
            n++;
            if (!adc_cs_n_o) flag = 1'b1;
        end
        check("to_window", 32'((200 + n) >= 250 && (200 + n) <= 260), 32'd1);
        check("to_set", 32'(timeout_o), 32'd1);
        check("to_idle", 32'(busy_o), 32'd0);
        check("to_cs_n", 32'(flag), 32'd0);
        check("to_fcnt", 32'(frame_cnt_o), 32'(exp_frames));
        clr_i = 1'b1;
        cyc(1);
        clr_i = 1'b0;
        check("to_clr", 32'(timeout_o), 32'd0);

        // Reset in the middle of channel 5 read
        frame_base = 16'($urandom);
        push_frame(frame_base);
        start_conv();
        cyc(2);
        busy_i = 1'b1;
        cyc(3);
        busy_i = 1'b0;
        n = 0;
        while (!(got_q.size() >= 5 && !adc_rd_n_o) && n < 300) begin
            cyc(1);
            n++;
        end
        check("mrst_reach", 32'(n < 300), 32'd1);
        #1;
        reset_i = 1'b0;
        #1;
        check("mrst_cs_n", 32'(adc_cs_n_o), 32'd1);
        check("mrst_rd_n", 32'(adc_rd_n_o), 32'd1);
        check("mrst_valid", 32'(sample_valid_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_fcnt", 32'(frame_cnt_o), 32'd0);
        check("mrst_flags", 32'({overrun_o, timeout_o}), 32'd0);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        compare("mrst_prefix");
        exp_frames = 16'd0;
        cyc(2);
        reset_i = 1'b1;
        cyc(2);
        run_frame(16'($urandom), 3, 12);
        cyc(2);
        compare("mrst_after");
        check("mrst_after_fcnt", 32'(frame_cnt_o), 32'(exp_frames));

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        cyc(1);
        release dut.frame_cnt_q;
        exp_frames = 16'hFFFF;
        check("wrap_preload", 32'(frame_cnt_o), 32'hFFFF);
        run_frame(16'($urandom), 2, 8);
        cyc(2);
        compare("wrap");
        check("wrap_fcnt", 32'(frame_cnt_o), 32'(exp_frames));

        // Conversion edge ignored while disabled
        en_i = 1'b0;
        start_conv();
        flag = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (busy_o || !adc_cs_n_o) flag = 1'b1;
        end
        check("dis_no_act", 32'(flag), 32'd0);
        check("dis_ovr", 32'(overrun_o), 32'd0);
        check("dis_fcnt", 32'(frame_cnt_o), 32'(exp_frames));
        check("dis_no_smp", 32'(got_q.size()), 32'd0);
        en_i = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
